// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver.
//   spi_rx_state_e   : receiver FSM state encoding (idle / frame active)
//   SPI_WORD_W       : default bits per received word
//   SPI_SYNC_STAGES  : default synchronizer depth for the SPI pins
package spi_pkg;

  localparam int SPI_WORD_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    SPI_RX_IDLE   = 1'b0,
    SPI_RX_ACTIVE = 1'b1
  } spi_rx_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus a one-cycle
// history register of the synchronized value so the parent can detect edges.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   din          : raw asynchronous pin
//   sync         : pin value after STAGES flops
//   last         : sync delayed by one clock (edge = sync != last)
// Parameters:
//   STAGES       : synchronizer depth (>= 2)
//   RESET_VAL    : idle level of the pin, loaded into every flop on reset
module spi_input_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = SPI_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic last
);

  logic [STAGES-1:0] chain;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      last  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      last  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave receiver: synchronizes ss_n/sclk/mosi into the clock
// domain, deserializes MSB-first words and offers them on valid/ready.
// Ports:
//   clock, reset      : system clock, asynchronous active-high reset
//   ss_n, sclk, mosi  : SPI pins from the master (asynchronous)
//   rx_data, rx_valid : received word, held until rx_ready accepts it
//   rx_ready          : consumer acceptance
//   busy              : a frame is in progress
//   overrun           : 1-cycle pulse when a word is dropped (previous unaccepted)
//   frame_err         : only with SPI_RX_FRAME_ERR_EN defined; 1-cycle pulse
//                       when a frame ends part-way through a word
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int WORD_W      = SPI_WORD_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
`ifdef SPI_RX_FRAME_ERR_EN
  output logic              frame_err,
`endif
  output logic              overrun
);

  localparam int CNT_W = $clog2(WORD_W);

  logic ss_sync, ss_last, sclk_sync, sclk_last, mosi_sync;
  // mosi is only sampled on sclk edges, so its history output is not needed.
  logic mosi_last_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .din(ss_n), .sync(ss_sync), .last(ss_last)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock(clock), .reset(reset), .din(sclk), .sync(sclk_sync), .last(sclk_last)
  );
  // Same depth as sclk so the data bit lines up with its clock edge.
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .din(mosi), .sync(mosi_sync), .last(mosi_last_unused)
  );

  logic ss_fall, ss_rise, sclk_rise;
  assign ss_fall   = ss_last & ~ss_sync;
  assign ss_rise   = ~ss_last & ss_sync;
  assign sclk_rise = ~sclk_last & sclk_sync;

  // ---------------------------------------------------------------- FSM
  spi_rx_state_e state, state_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SPI_RX_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first means every path writes state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      SPI_RX_IDLE:   if (ss_fall) state_nxt = SPI_RX_ACTIVE;
      SPI_RX_ACTIVE: if (ss_rise) state_nxt = SPI_RX_IDLE;
      default:       state_nxt = SPI_RX_IDLE;
    endcase
  end

  assign busy = (state == SPI_RX_ACTIVE);

  // ------------------------------------------------- bit counter / shifter
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-2:0] shift;
  logic [WORD_W-1:0] next_word;
  logic [WORD_W-1:0] done_word;
  logic              done;

  assign next_word = {shift, mosi_sync};

  // A finished word is parked in done_word for one cycle and handed to the
  // output register on the following clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift     <= '0;
      done_word <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == SPI_RX_IDLE) begin
        if (ss_fall) bit_cnt <= '0;
      end else if (ss_rise) begin
        // Frame end wins over a coincident sclk edge; any partial word is dropped.
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift <= next_word[WORD_W-2:0];
        if (bit_cnt == CNT_W'(WORD_W - 1)) begin
          bit_cnt   <= '0;
          done      <= 1'b1;
          done_word <= next_word;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------ output handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          // Either empty, or the held word is accepted this very cycle.
          rx_data  <= done_word;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= (state == SPI_RX_ACTIVE) && ss_rise && (bit_cnt != '0);
  end
`endif

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Self-checking bench for spi_slave_receiver (default WORD_W=8, SYNC_STAGES=2).
// Honours SPI_RX_FRAME_ERR_EN when defined.
module tb_spi_slave_receiver;

  localparam int W   = 8;
  localparam int LAT = 2 + 2;  // synchronizer depth + 2 clocks, pin edge -> rx_valid

  logic         clock = 1'b0;
  logic         reset;
  logic         ss_n, sclk, mosi, rx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, busy, overrun;
`ifdef SPI_RX_FRAME_ERR_EN
  logic         frame_err;
`endif

  spi_slave_receiver dut (
    .clock(clock), .reset(reset), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ------------------------------------------------------------ monitor
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int ovr_cnt, ferr_cnt, valid_cycles;

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (overrun) ovr_cnt++;
      if (rx_valid) valid_cycles++;
`ifdef SPI_RX_FRAME_ERR_EN
      if (frame_err) ferr_cnt++;
`endif
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic spi_bit(input logic b, input int half);
    sclk = 1'b0;
    mosi = b;
    repeat (half) tick();
    sclk = 1'b1;
    repeat (half) tick();
    sclk = 1'b0;
  endtask

  task automatic spi_word(input logic [W-1:0] w, input int half);
    for (int i = W - 1; i >= 0; i--) spi_bit(w[i], half);
  endtask

  // Sends a word but returns right after the last sclk rise is driven.
  task automatic spi_word_open(input logic [W-1:0] w, input int half);
    for (int i = W - 1; i >= 1; i--) spi_bit(w[i], half);
    sclk = 1'b0;
    mosi = w[0];
    repeat (half) tick();
    sclk = 1'b1;
  endtask

  task automatic ss_begin(input string tag);
    ss_n = 1'b0;
    repeat (3) tick();
    check({tag, "_busy_on"}, busy, 1'b1);
  endtask

  task automatic ss_end(input string tag);
    repeat (2) tick();
    ss_n = 1'b1;
    repeat (6) tick();
    check({tag, "_busy_off"}, busy, 1'b0);
  endtask

  task automatic drain(input string tag);
    repeat (12) tick();
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_counts();
    ovr_cnt = 0;
    ferr_cnt = 0;
    valid_cycles = 0;
  endtask

  initial begin
    int exp_ferr;
    reset = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; rx_ready = 1'b1;
    #1;
    check("rst_data", rx_data, '0);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();

    // 1: single word 0xA5, exact latency after the 8th rise
    clear_counts();
    ss_begin("t1");
    spi_word_open(8'hA5, 4);
    repeat (LAT - 1) tick();
    check("t1_lat_early", rx_valid, 1'b0);
    tick();
    check("t1_lat_valid", rx_valid, 1'b1);
    check("t1_lat_data", rx_data, 8'hA5);
    repeat (3) tick();
    sclk = 1'b0;
    ss_end("t1");
    exp_q.push_back(8'hA5);
    drain("t1");
    check("t1_overrun", ovr_cnt, 0);

    // 2: consumer stalled across two words -> second dropped with overrun
    clear_counts();
    rx_ready = 1'b0;
    ss_begin("t2");
    spi_word(8'h3C, 4);
    spi_word(8'hC3, 4);
    ss_end("t2");
    repeat (5) tick();
    check("t2_hold_valid", rx_valid, 1'b1);
    check("t2_hold_data", rx_data, 8'h3C);
    check("t2_overrun", ovr_cnt, 1);
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    drain("t2");

    // 3: acceptance in the completion cycle of word 2
    clear_counts();
    rx_ready = 1'b0;
    ss_begin("t3");
    spi_word(8'h3C, 4);
    spi_word_open(8'hC3, 4);
    repeat (LAT - 1) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t3_valid", rx_valid, 1'b1);
    check("t3_data", rx_data, 8'hC3);
    check("t3_overrun_now", overrun, 1'b0);
    tick();
    sclk = 1'b0;
    ss_end("t3");
    check("t3_overrun", ovr_cnt, 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    drain("t3");

    // 4: truncated frame, then full frame 0x81
    clear_counts();
    ss_begin("t4a");
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), 3);
    ss_end("t4a");
    ss_begin("t4b");
    spi_word(8'h81, 3);
    ss_end("t4b");
    exp_q.push_back(8'h81);
    drain("t4");
`ifdef SPI_RX_FRAME_ERR_EN
    check("t4_frame_err", ferr_cnt, 1);
`endif

    // 5: sclk activity with slave deselected is ignored
    clear_counts();
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(0, 1)), 2);
    repeat (6) tick();
    check("t5_busy", busy, 1'b0);
    check("t5_valid_cycles", valid_cycles, 0);
    drain("t5");

    // 6: reset in the middle of a frame
    clear_counts();
    ss_begin("t6");
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 3);
    reset = 1'b1;
    #1;
    check("t6_rst_data", rx_data, '0);
    check("t6_rst_valid", rx_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_overrun", overrun, 1'b0);
    ss_n = 1'b1;
    repeat (3) tick();
    check("t6_rst_busy_held", busy, 1'b0);
    reset = 1'b0;
    repeat (4) tick();
    ss_begin("t6b");
    spi_word(8'hFF, 3);
    ss_end("t6b");
    exp_q.push_back(8'hFF);
    drain("t6");

    // Random frames: random word count, rate and truncated tail; consumer always ready
    clear_counts();
    exp_ferr = 0;
    for (int f = 0; f < 20; f++) begin
      int half, nw, part;
      half = $urandom_range(2, 5);
      nw   = $urandom_range(1, 3);
      part = $urandom_range(0, W - 1);
      ss_begin($sformatf("rnd%0d", f));
      for (int k = 0; k < nw; k++) begin
        logic [W-1:0] w;
        w = W'($urandom_range(0, 255));
        spi_word(w, half);
        exp_q.push_back(w);
      end
      for (int b = 0; b < part; b++) spi_bit(1'($urandom_range(0, 1)), half);
      if (part != 0) exp_ferr++;
      ss_end($sformatf("rnd%0d", f));
    end
    drain("rnd");
    check("rnd_overrun", ovr_cnt, 0);
`ifdef SPI_RX_FRAME_ERR_EN
    check("rnd_frame_err", ferr_cnt, exp_ferr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
